seq_alu: RTL and testbench

Parametrised multi-cycle ALU for the Y86 pipeline execute stage. Extends the 64-bit add/sub/and/xor ALU to a configurable operand width, adds shift operations and an iterative multiply, and adds a registered condition-code set (ZF/SF/OF). It uses a valid/ready input handshake and a cancel input for pipeline flushes. The execute stage stalls on `in_ready` low while a multiply runs.

---
 rtl/seq_alu.sv | 154 +++++++++++++++
 tb/tb_seq_alu.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: Y86 execute-stage ALU with single-cycle add/sub/logic/shift ops,
// an iterative shift-add multiply, and a registered {ZF,SF,OF} flag set.
module seq_alu #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             set_cc,
    input  logic             cancel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [2:0]       cc
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SAR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q, a_next, b_q, b_next;
    logic [WIDTH-1:0] acc, acc_next, out_next;
    logic [SHW-1:0]   cnt, cnt_next;
    logic [2:0]       sel_q, sel_next, cc_next;
    logic             setcc_q, setcc_next;
    logic             pend, pend_next, valid_next;
    logic [WIDTH-1:0] sum, diff, mul_sum, alu_res;
    logic [SHW-1:0]   shamt;
    logic             alu_of, accept;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready & ~cancel;
    assign sum      = a_q + b_q;
    assign diff     = a_q - b_q;
    assign shamt    = b_q[SHW-1:0];
    // a_q/b_q double as multiplicand/multiplier while in MUL
    assign mul_sum  = acc + (b_q[0] ? a_q : '0);

    // Single-cycle result from the operands captured at accept
    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        case (sel_q)
            OP_ADD: begin
                alu_res = sum;
                alu_of  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_of  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SHL:  alu_res = a_q << shamt;
            OP_SAR:  alu_res = $signed(a_q) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_next = state;
        a_next     = a_q;
        b_next     = b_q;
        acc_next   = acc;
        cnt_next   = cnt;
        sel_next   = sel_q;
        setcc_next = setcc_q;
        pend_next  = 1'b0;
        out_next   = out;
        valid_next = 1'b0;
        cc_next    = cc;

        if (pend) begin
            out_next   = alu_res;
            valid_next = 1'b1;
            if (setcc_q) cc_next = {alu_res == '0, alu_res[WIDTH-1], alu_of};
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    a_next     = i_a;
                    b_next     = i_b;
                    sel_next   = select;
                    setcc_next = set_cc;
                    if (select == OP_MUL) begin
                        state_next = MUL;
                        acc_next   = '0;
                        cnt_next   = '0;
                    end else begin
                        pend_next = 1'b1;
                    end
                end
            end
            MUL: begin
                if (cancel) begin
                    state_next = IDLE;
                end else begin
                    acc_next = mul_sum;
                    a_next   = a_q << 1;
                    b_next   = b_q >> 1;
                    cnt_next = cnt + SHW'(1);
                    if (cnt == LAST_ITER) begin
                        state_next = IDLE;
                        out_next   = mul_sum;
                        valid_next = 1'b1;
                        if (setcc_q) cc_next = {mul_sum == '0, mul_sum[WIDTH-1], 1'b0};
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
            sel_q     <= '0;
            setcc_q   <= 1'b0;
            pend      <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            cc        <= 3'b100;
        end else begin
            state     <= state_next;
            a_q       <= a_next;
            b_q       <= b_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            sel_q     <= sel_next;
            setcc_q   <= setcc_next;
            pend      <= pend_next;
            out       <= out_next;
            out_valid <= valid_next;
            cc        <= cc_next;
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: 64-bit instance for reset/flags/stream,
// 8-bit for shifts, 16-bit for multiply and cancel.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  select = 3'b000;
    logic [63:0] a = '0, b = '0;
    logic        set_cc = 1'b0, cancel = 1'b0;
    logic        v64 = 1'b0, v8 = 1'b0, v16 = 1'b0;

    logic        rdy64, ov64, rdy8, ov8, rdy16, ov16;
    logic [63:0] out64;
    logic [7:0]  out8;
    logic [15:0] out16;
    logic [2:0]  cc64, cc8, cc16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(64)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(rdy64), .select(select),
        .i_a(a), .i_b(b), .set_cc(set_cc), .cancel(cancel),
        .out(out64), .out_valid(ov64), .cc(cc64));
    seq_alu #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .select(select),
        .i_a(a[7:0]), .i_b(b[7:0]), .set_cc(set_cc), .cancel(cancel),
        .out(out8), .out_valid(ov8), .cc(cc8));
    seq_alu #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16), .select(select),
        .i_a(a[15:0]), .i_b(b[15:0]), .set_cc(set_cc), .cancel(cancel),
        .out(out16), .out_valid(ov16), .cc(cc16));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one request for one cycle on the chosen instance, then step to its completion edge
    task automatic issue(input int id, input logic [2:0] s, input logic [63:0] x, input logic [63:0] y,
                         input logic sc);
        select = s; a = x; b = y; set_cc = sc;
        v64 = (id == 64); v8 = (id == 8); v16 = (id == 16);
        cyc();
        v64 = 1'b0; v8 = 1'b0; v16 = 1'b0;
        cyc();
    endtask

    // Reference result and flags for 64-bit single-cycle ops
    task automatic model(input logic [2:0] s, input logic [63:0] x, input logic [63:0] y,
                         input logic sc, input logic [2:0] cin,
                         output logic [63:0] r, output logic [2:0] cout);
        logic [64:0] wide;
        logic        of;
        wide = '0;
        of   = 1'b0;
        case (s)
            3'd0: begin wide = {x[63], x} + {y[63], y}; r = wide[63:0]; of = wide[64] ^ wide[63]; end
            3'd1: begin wide = {x[63], x} - {y[63], y}; r = wide[63:0]; of = wide[64] ^ wide[63]; end
            3'd2: r = x & y;
            3'd3: r = x ^ y;
            3'd4: r = x << y[5:0];
            3'd5: r = $signed(x) >>> y[5:0];
            default: r = '0;
        endcase
        cout = sc ? {r == 64'd0, r[63], of} : cin;
    endtask

    task automatic test_reset();
        cyc();
        n_cmp++;
        if (out64 !== 64'd0 || ov64 !== 1'b0 || cc64 !== 3'b100 || rdy64 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_init: out=%h ov=%b cc=%b rdy=%b want 0/0/100/1", out64, ov64, cc64, rdy64);
        end
        rst_n = 1'b1;
        select = 3'b110; a = 64'd3; b = 64'd5; v64 = 1'b1;
        cyc();
        v64 = 1'b0;
        n_cmp++;
        if (rdy64 !== 1'b0) begin
            n_bad++;
            $display("FAIL mul64_busy: rdy=%b want 0", rdy64);
        end
        repeat (5) cyc();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out64 !== 64'd0 || ov64 !== 1'b0 || cc64 !== 3'b100 || rdy64 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_midmul: out=%h ov=%b cc=%b rdy=%b want 0/0/100/1", out64, ov64, cc64, rdy64);
        end
        cyc();
        rst_n = 1'b1;
        issue(64, 3'b000, 64'd1, 64'd1, 1'b0);
        n_cmp++;
        if (ov64 !== 1'b1 || out64 !== 64'd2) begin
            n_bad++;
            $display("FAIL add_after_reset: ov=%b out=%h want 1/2", ov64, out64);
        end
    endtask

    task automatic test_flags();
        issue(64, 3'b000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        n_cmp++;
        if (out64 !== 64'h8000_0000_0000_0000 || cc64 !== 3'b011) begin
            n_bad++;
            $display("FAIL add_ovf: out=%h cc=%b want 8000000000000000/011", out64, cc64);
        end
        issue(64, 3'b001, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
        n_cmp++;
        if (out64 !== 64'h7FFF_FFFF_FFFF_FFFF || cc64 !== 3'b001) begin
            n_bad++;
            $display("FAIL sub_ovf: out=%h cc=%b want 7fffffffffffffff/001", out64, cc64);
        end
        issue(64, 3'b011, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0);
        n_cmp++;
        if (out64 !== 64'd0 || cc64 !== 3'b001 || ov64 !== 1'b1) begin
            n_bad++;
            $display("FAIL xor_nocc: out=%h cc=%b ov=%b want 0/001/1", out64, cc64, ov64);
        end
        issue(64, 3'b111, 64'd5, 64'd6, 1'b1);
        n_cmp++;
        if (out64 !== 64'd0 || cc64 !== 3'b100) begin
            n_bad++;
            $display("FAIL reserved: out=%h cc=%b want 0/100", out64, cc64);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_out [100];
        logic [2:0]  exp_cc  [100];
        logic [2:0]  mcc;
        logic [2:0]  s;
        logic [63:0] x, y;
        logic        sc;
        mcc = 3'b100;
        for (int i = 0; i < 100; i++) begin
            s  = 3'($urandom_range(0, 6));
            if (s == 3'b110) s = 3'b111;
            x  = {$urandom, $urandom};
            y  = (i % 4 == 0) ? x : {$urandom, $urandom};
            sc = 1'($urandom_range(0, 1));
            model(s, x, y, sc, mcc, exp_out[i], exp_cc[i]);
            mcc = exp_cc[i];
            select = s; a = x; b = y; set_cc = sc; v64 = 1'b1;
            cyc();
            if (i > 0) begin
                n_cmp++;
                if (ov64 !== 1'b1 || out64 !== exp_out[i-1] || cc64 !== exp_cc[i-1]) begin
                    n_bad++;
                    $display("FAIL stream[%0d]: ov=%b out=%h cc=%b want 1/%h/%b",
                             i - 1, ov64, out64, cc64, exp_out[i-1], exp_cc[i-1]);
                end
            end
        end
        v64 = 1'b0;
        cyc();
        n_cmp++;
        if (ov64 !== 1'b1 || out64 !== exp_out[99] || cc64 !== exp_cc[99]) begin
            n_bad++;
            $display("FAIL stream[99]: ov=%b out=%h cc=%b want 1/%h/%b", ov64, out64, cc64, exp_out[99], exp_cc[99]);
        end
        cyc();
        n_cmp++;
        if (ov64 !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_drain: ov=%b want 0", ov64);
        end
    endtask

    task automatic test_shift();
        issue(8, 3'b100, 64'h81, 64'd9, 1'b1);
        n_cmp++;
        if (ov8 !== 1'b1 || out8 !== 8'h02 || cc8 !== 3'b000) begin
            n_bad++;
            $display("FAIL shl8: ov=%b out=%h cc=%b want 1/02/000", ov8, out8, cc8);
        end
        issue(8, 3'b101, 64'h80, 64'd3, 1'b1);
        n_cmp++;
        if (out8 !== 8'hF0 || cc8 !== 3'b010) begin
            n_bad++;
            $display("FAIL sar8: out=%h cc=%b want f0/010", out8, cc8);
        end
        cyc();
        n_cmp++;
        if (ov8 !== 1'b0 || out8 !== 8'hF0) begin
            n_bad++;
            $display("FAIL pulse8: ov=%b out=%h want 0/f0", ov8, out8);
        end
    endtask

    task automatic test_mul();
        select = 3'b110; a = 64'hFFFD; b = 64'd7; set_cc = 1'b1; v16 = 1'b1;
        cyc();
        v16 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (rdy16 !== 1'b0 || ov16 !== 1'b0) begin
                n_bad++;
                $display("FAIL mul_wait[%0d]: rdy=%b ov=%b want 0/0", i, rdy16, ov16);
            end
            if (i == 4) begin
                select = 3'b000; a = 64'd1; b = 64'd1; v16 = 1'b1;
            end else begin
                v16 = 1'b0;
            end
            cyc();
        end
        n_cmp++;
        if (ov16 !== 1'b1 || out16 !== 16'hFFEB || cc16 !== 3'b010 || rdy16 !== 1'b1) begin
            n_bad++;
            $display("FAIL mul_done: ov=%b out=%h cc=%b rdy=%b want 1/ffeb/010/1", ov16, out16, cc16, rdy16);
        end
        cyc();
        n_cmp++;
        if (ov16 !== 1'b0 || out16 !== 16'hFFEB) begin
            n_bad++;
            $display("FAIL mul_ignored: ov=%b out=%h want 0/ffeb", ov16, out16);
        end
    endtask

    task automatic test_cancel();
        logic seen;
        select = 3'b110; a = 64'd5; b = 64'd5; set_cc = 1'b1; v16 = 1'b1;
        cyc();
        v16 = 1'b0;
        repeat (7) cyc();
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        n_cmp++;
        if (rdy16 !== 1'b1 || ov16 !== 1'b0) begin
            n_bad++;
            $display("FAIL cancel_ready: rdy=%b ov=%b want 1/0", rdy16, ov16);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (ov16 === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0 || out16 !== 16'hFFEB || cc16 !== 3'b010) begin
            n_bad++;
            $display("FAIL cancel_hold: ov_seen=%b out=%h cc=%b want 0/ffeb/010", seen, out16, cc16);
        end
        select = 3'b000; a = 64'd2; b = 64'd3; cancel = 1'b1; v16 = 1'b1;
        cyc();
        v16 = 1'b0; cancel = 1'b0;
        cyc();
        n_cmp++;
        if (ov16 !== 1'b0 || out16 !== 16'hFFEB) begin
            n_bad++;
            $display("FAIL cancel_idle: ov=%b out=%h want 0/ffeb", ov16, out16);
        end
    endtask

    initial begin
        test_reset();
        test_flags();
        test_back_to_back();
        test_shift();
        test_mul();
        test_cancel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
